// File: rtl/booth_iter_counter.sv
// Iteration counter and sequencing FSM for the Booth multiplier datapath.
// Optional radix-4 step (2 per decrement) enabled by defining BOOTH_CNT_RADIX4_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; count holds, decr ignored
// RUN   | counting down by step on each decr
// DONE  | one-cycle completion pulse; start here reloads back-to-back
module booth_iter_counter #(
   parameter int COUNT_WIDTH  = 5,
   parameter int DEFAULT_LOAD = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] load_val,
   input  logic                   decr,
   input  logic                   abort,
`ifdef BOOTH_CNT_RADIX4_EN
   input  logic                   radix4,
`endif
   output logic [COUNT_WIDTH-1:0] count_out,
   output logic                   busy,
   output logic                   last,
   output logic                   done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [1:0]             step_q, step_d;
   logic [COUNT_WIDTH-1:0] step_ext;
   logic [COUNT_WIDTH-1:0] load_cnt;
   logic                   radix4_sel;

`ifdef BOOTH_CNT_RADIX4_EN
   assign radix4_sel = radix4;
`else
   assign radix4_sel = 1'b0;
`endif

   assign step_ext = COUNT_WIDTH'(step_q);
   assign load_cnt = (load_val == '0) ? COUNT_WIDTH'(DEFAULT_LOAD) : load_val;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         step_q  <= 2'd1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         step_q  <= step_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      step_d  = step_q;
      if (abort) begin
         state_d = IDLE;
         count_d = '0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               state_d = IDLE;
               if (start) begin
                  state_d = RUN;
                  count_d = load_cnt;
                  step_d  = radix4_sel ? 2'd2 : 2'd1;
               end
            end
            RUN: begin
               if (decr) begin
                  // Saturate at zero so odd counts with a step of 2 never wrap.
                  if (count_q > step_ext) begin
                     count_d = count_q - step_ext;
                  end else begin
                     count_d = '0;
                     state_d = DONE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   assign count_out = count_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign last      = busy && (count_q <= step_ext);

endmodule

// File: tb/tb_booth_iter_counter.sv
// Self-checking bench for booth_iter_counter: directed scenarios plus a
// randomized run against a behavioural model (radix-4 when BOOTH_CNT_RADIX4_EN).
module tb_booth_iter_counter;

   localparam int CW   = 5;
   localparam int DEFL = 16;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [CW-1:0] load_val;
   logic          decr;
   logic          abort;
`ifdef BOOTH_CNT_RADIX4_EN
   logic          radix4;
`endif
   logic [CW-1:0] count_out;
   logic          busy;
   logic          last;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural reference: remaining count, whether a sequence is active,
   // and whether this cycle is the completion pulse.
   int m_cnt  = 0;
   int m_step = 1;
   bit m_busy = 0;
   bit m_done = 0;

   booth_iter_counter #(.COUNT_WIDTH(CW), .DEFAULT_LOAD(DEFL)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .load_val  (load_val),
      .decr      (decr),
      .abort     (abort),
`ifdef BOOTH_CNT_RADIX4_EN
      .radix4    (radix4),
`endif
      .count_out (count_out),
      .busy      (busy),
      .last      (last),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [CW+2:0] model_vec();
      bit m_last;
      m_last = m_busy && (m_cnt <= m_step);
      return {CW'(m_cnt), m_busy, m_last, m_done};
   endfunction

   task automatic model_update();
      m_done = 0;
      if (abort) begin
         m_busy = 0;
         m_cnt  = 0;
      end else if (start && !m_busy) begin
         m_cnt  = (load_val == 0) ? DEFL : int'(load_val);
         m_step = 1;
`ifdef BOOTH_CNT_RADIX4_EN
         if (radix4) m_step = 2;
`endif
         m_busy = 1;
      end else if (decr && m_busy) begin
         if (m_cnt > m_step) begin
            m_cnt = m_cnt - m_step;
         end else begin
            m_cnt  = 0;
            m_busy = 0;
            m_done = 1;
         end
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_step = 1;
      m_busy = 0;
      m_done = 0;
   endtask

   // One clock: inputs already driven are sampled on the edge, then settle.
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      start    = 1'b0;
      load_val = '0;
      decr     = 1'b0;
      abort    = 1'b0;
`ifdef BOOTH_CNT_RADIX4_EN
      radix4   = 1'b0;
`endif
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      model_reset();
      #12;
      n_checks++;
      if ({count_out, busy, last, done} !== '0) begin
         $display("FAIL reset_values: got count=%0d busy=%b last=%b done=%b, want all 0",
                  count_out, busy, last, done);
         n_errors++;
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      n_checks++;
      if ({count_out, busy, done} !== '0) begin
         $display("FAIL reset_idle: got count=%0d busy=%b done=%b, want 0 0 0",
                  count_out, busy, done);
         n_errors++;
      end
   endtask

   task automatic test_default_load();
      start = 1'b1; load_val = '0; decr = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (count_out !== 5'd16 || busy !== 1'b1) begin
         $display("FAIL default_load: got count=%0d busy=%b, want 16 1", count_out, busy);
         n_errors++;
      end
      for (int i = 1; i <= 16; i++) begin
         n_checks++;
         if (last !== ((17 - i) == 1)) begin
            $display("FAIL default_last: at count=%0d got last=%b, want %b",
                     count_out, last, ((17 - i) == 1));
            n_errors++;
         end
         tick();
         n_checks++;
         if (i < 16) begin
            if (count_out !== CW'(16 - i) || busy !== 1'b1 || done !== 1'b0) begin
               $display("FAIL default_step: decr %0d got count=%0d busy=%b done=%b, want %0d 1 0",
                        i, count_out, busy, done, 16 - i);
               n_errors++;
            end
         end else if (count_out !== '0 || busy !== 1'b0 || done !== 1'b1) begin
            $display("FAIL default_done: got count=%0d busy=%b done=%b, want 0 0 1",
                     count_out, busy, done);
            n_errors++;
         end
      end
      decr = 1'b0;
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL default_done_width: got done=%b busy=%b, want 0 0", done, busy);
         n_errors++;
      end
   endtask

   task automatic test_decr_toggle();
      int nd;
      nd = 0;
      start = 1'b1; load_val = 5'd5; decr = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         decr = (k % 2 == 0);
         tick();
         if (decr && nd < 5) nd++;
         n_checks++;
         if (count_out !== CW'(5 - nd) || done !== (decr && nd == 5 && k == 8)) begin
            $display("FAIL toggle_step: k=%0d got count=%0d done=%b, want %0d %b",
                     k, count_out, done, 5 - nd, (decr && nd == 5 && k == 8));
            n_errors++;
         end
      end
      decr = 1'b1;
      tick();
      decr = 1'b0;
      n_checks++;
      if (count_out !== '0 || busy !== 1'b0) begin
         $display("FAIL idle_decr: got count=%0d busy=%b, want 0 0", count_out, busy);
         n_errors++;
      end
   endtask

   task automatic test_abort();
      start = 1'b1; load_val = 5'd8; decr = 1'b0;
      tick();
      start = 1'b0; decr = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (count_out !== 5'd5) begin
         $display("FAIL abort_pre: got count=%0d, want 5", count_out);
         n_errors++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0; decr = 1'b0;
      n_checks++;
      if (count_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL abort_run: got count=%0d busy=%b done=%b, want 0 0 0",
                  count_out, busy, done);
         n_errors++;
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         $display("FAIL abort_no_done: got done=%b, want 0", done);
         n_errors++;
      end
      start = 1'b1; abort = 1'b1; load_val = 5'd4;
      tick();
      start = 1'b0; abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || count_out !== '0) begin
         $display("FAIL start_abort: got busy=%b count=%0d, want 0 0", busy, count_out);
         n_errors++;
      end
   endtask

   task automatic test_back_to_back();
      start = 1'b1; load_val = 5'd2; decr = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      n_checks++;
      if (done !== 1'b1) begin
         $display("FAIL b2b_first_done: got done=%b, want 1", done);
         n_errors++;
      end
      start = 1'b1; load_val = 5'd3;
      tick();
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || count_out !== 5'd3 || done !== 1'b0) begin
         $display("FAIL b2b_reload: got busy=%b count=%0d done=%b, want 1 3 0",
                  busy, count_out, done);
         n_errors++;
      end
      repeat (3) tick();
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL b2b_second_done: got done=%b busy=%b, want 1 0", done, busy);
         n_errors++;
      end
      decr = 1'b0;
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         $display("FAIL b2b_pulse: got done=%b, want 0", done);
         n_errors++;
      end
   endtask

   task automatic test_radix4();
      int step;
      int exp;
      int n;
      step = 1;
`ifdef BOOTH_CNT_RADIX4_EN
      radix4 = 1'b1;
      step = 2;
`endif
      start = 1'b1; load_val = 5'd7; decr = 1'b0;
      tick();
      start = 1'b0;
`ifdef BOOTH_CNT_RADIX4_EN
      radix4 = 1'b0;
`endif
      exp = 7;
      n = 0;
      decr = 1'b1;
      while (exp > 0) begin
         n_checks++;
         if (count_out !== CW'(exp) || last !== (exp <= step)) begin
            $display("FAIL step_seq: got count=%0d last=%b, want %0d %b",
                     count_out, last, exp, (exp <= step));
            n_errors++;
         end
         exp = (exp > step) ? exp - step : 0;
         n++;
         tick();
      end
      decr = 1'b0;
      n_checks++;
      if (done !== 1'b1 || count_out !== '0 || n !== (7 + step - 1) / step) begin
         $display("FAIL step_done: got done=%b count=%0d after %0d decr, want 1 0 after %0d",
                  done, count_out, n, (7 + step - 1) / step);
         n_errors++;
      end
      tick();
   endtask

   task automatic test_async_reset();
      start = 1'b1; load_val = 5'd12; decr = 1'b0;
      tick();
      start = 1'b0; decr = 1'b1;
      repeat (3) tick();
      decr = 1'b0;
      n_checks++;
      if (count_out !== 5'd9 || busy !== 1'b1) begin
         $display("FAIL async_pre: got count=%0d busy=%b, want 9 1", count_out, busy);
         n_errors++;
      end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({count_out, busy, last, done} !== '0) begin
         $display("FAIL async_reset: got count=%0d busy=%b last=%b done=%b, want all 0",
                  count_out, busy, last, done);
         n_errors++;
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0 || count_out !== '0) begin
         $display("FAIL async_idle: got busy=%b count=%0d, want 0 0", busy, count_out);
         n_errors++;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         start    = ($urandom_range(3) == 0);
         load_val = CW'($urandom_range(31));
         decr     = ($urandom_range(1) == 1);
         abort    = ($urandom_range(19) == 0);
`ifdef BOOTH_CNT_RADIX4_EN
         radix4   = ($urandom_range(1) == 1);
`endif
         tick();
         n_checks++;
         if ({count_out, busy, last, done} !== model_vec()) begin
            $display("FAIL random_cycle %0d: got {count,busy,last,done}=%h, want %h",
                     c, {count_out, busy, last, done}, model_vec());
            n_errors++;
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_default_load();
      test_decr_toggle();
      test_abort();
      test_back_to_back();
      test_radix4();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
